c3lib_sync3_share_sched: RTL and testbench

// - Time-multiplexes NSRC quasi-static async status buses through ONE shared 3-stage sync bank (DWIDTH bits).
// - Per-source request or continuous autoscan, round-robin fair; a per-source snapshot is held in the clk domain.
// - Sits between slow async status sources (PHY calibration/lock flags) and register/control logic.
// - Cuts flop count vs. NSRC separate synchronizer banks.
//

---
 rtl/c3lib_sync_sched_pkg.sv | 14 +
 rtl/c3lib_rr_arb.sv | 36 +++
 rtl/c3lib_sync3_ulvt_bitsync.sv | 31 +++
 rtl/c3lib_sync3_share_sched.sv | 127 ++++++++++++
 tb/tb_c3lib_sync3_share_sched.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/c3lib_sync_sched_pkg.sv
// Shared types and constants for the shared-synchronizer scheduler.
// Holds the scheduler state encoding and the minimum settle time.
package c3lib_sync_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } sched_state_e;

    // Three sync stages must fill with the new source before capture.
    localparam int SETTLE_MIN = 3;

endpackage

// File: rtl/c3lib_rr_arb.sv
// Rotating-priority first-one finder.
// Returns the first set bit of req at or after ptr, wrapping from N-1 to 0.
module c3lib_rr_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx
);

    logic found;

    // First pass covers ptr..N-1; the second pass picks up the wrap 0..ptr-1.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && (IW'(k) >= ptr) && req[k]) begin
                found       = 1'b1;
                grant_oh[k] = 1'b1;
                grant_idx   = IW'(k);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!found && req[k]) begin
                found       = 1'b1;
                grant_oh[k] = 1'b1;
                grant_idx   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/c3lib_sync3_ulvt_bitsync.sv
// Three-stage multi-bit synchronizer bank, clocked every cycle.
// Bits are synchronized independently; callers must hold the input quasi-static.
module c3lib_sync3_ulvt_bitsync #(
    parameter int DWIDTH    = 1,
    parameter int RESET_VAL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out
);

    localparam logic [DWIDTH-1:0] FILL = (RESET_VAL != 0) ? '1 : '0;

    logic [DWIDTH-1:0] s1, s2, s3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= FILL;
            s2 <= FILL;
            s3 <= FILL;
        end else begin
            s1 <= data_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign data_out = s3;

endmodule

// File: rtl/c3lib_sync3_share_sched.sv
// Time-multiplexes NSRC async status buses through one shared 3-stage sync bank,
// holding a clk-domain snapshot per source.
module c3lib_sync3_share_sched
    import c3lib_sync_sched_pkg::*;
#(
    parameter int NSRC      = 4,
    parameter int DWIDTH    = 8,
    parameter int SETTLE    = 4,
    parameter int AUTOSCAN  = 1,
    parameter int RESET_VAL = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NSRC*DWIDTH-1:0]   src_data_in,
    input  logic [NSRC-1:0]          src_en,
    input  logic [NSRC-1:0]          src_req,
    output logic [NSRC*DWIDTH-1:0]   snap_data,
    output logic [NSRC-1:0]          snap_valid,
    output logic [NSRC-1:0]          snap_seen,
    output logic                     busy,
    output sched_state_e             state_dbg
);

    // Interface: src_req is a pulse or level with no acknowledge; snap_valid is a
    // one-cycle qualifier of the updated snap_data slice, with no backpressure.

    localparam int SEL_W = $clog2(NSRC);
    localparam int CNT_W = $clog2(SETTLE);
    localparam logic [NSRC*DWIDTH-1:0] SNAP_FILL = (RESET_VAL != 0) ? '1 : '0;

    if (SETTLE < SETTLE_MIN || NSRC < 2) begin : g_param_check
        $fatal(1, "c3lib_sync3_share_sched: SETTLE must be >= 3 and NSRC >= 2");
    end

    sched_state_e      state, state_nxt;
    logic [SEL_W-1:0]  sel, sel_nxt, rr_ptr, grant_idx;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [NSRC-1:0]   pending, cand_req, cand, grant_oh, cap_mask;
    logic              grant_any, capture;
    logic [DWIDTH-1:0] sync_in, sync_out;

    assign capture   = (state == ST_CAPTURE);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;
    assign grant_any = |grant_oh;

    // Autoscan only fills otherwise-idle time; real requests always win.
    always_comb begin
        cand_req = (pending | src_req) & src_en;
        cand     = cand_req;
        if (AUTOSCAN != 0 && cand_req == '0) cand = src_en;
    end

    c3lib_rr_arb #(.N(NSRC), .IW(SEL_W)) u_arb (
        .req       (cand),
        .ptr       (rr_ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sync_in  = '0;
        cap_mask = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SEL_W'(k)) begin
                sync_in     = src_data_in[k*DWIDTH +: DWIDTH];
                cap_mask[k] = capture;
            end
        end
    end

    c3lib_sync3_ulvt_bitsync #(.DWIDTH(DWIDTH), .RESET_VAL(RESET_VAL)) u_sync (
        .clk      (clk),
        .rst_n    (~rst),
        .data_in  (sync_in),
        .data_out (sync_out)
    );

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    sel_nxt   = grant_idx;
                    cnt_nxt   = CNT_W'(SETTLE - 1);
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) state_nxt = ST_CAPTURE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            ST_CAPTURE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sel        <= '0;
            cnt        <= '0;
            rr_ptr     <= '0;
            pending    <= '0;
            snap_data  <= SNAP_FILL;
            snap_valid <= '0;
            snap_seen  <= '0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            cnt        <= cnt_nxt;
            // A request arriving with its own capture survives; disable wins over both.
            pending    <= ((pending & ~cap_mask) | src_req) & src_en;
            snap_valid <= cap_mask;
            snap_seen  <= snap_seen | cap_mask;
            if (capture) begin
                rr_ptr <= (sel == SEL_W'(NSRC - 1)) ? '0 : sel + 1'b1;
            end
            for (int k = 0; k < NSRC; k++) begin
                if (cap_mask[k]) snap_data[k*DWIDTH +: DWIDTH] <= sync_out;
            end
        end
    end

endmodule

// File: tb/tb_c3lib_sync3_share_sched.sv
// Directed testbench for c3lib_sync3_share_sched: a request-driven instance
// (AUTOSCAN=0) and an autoscan instance (AUTOSCAN=1) share clock, reset and data.
module tb_c3lib_sync3_share_sched;
    import c3lib_sync_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] src_data_in;
    logic [3:0]  src_en0, src_en1, src_req;

    logic [31:0] snap_data0, snap_data1;
    logic [3:0]  snap_valid0, snap_valid1, snap_seen0, snap_seen1;
    logic        busy0, busy1;
    sched_state_e st0, st1;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];
    int         exp_cyc_q[$];

    always #5 clk = ~clk;

    c3lib_sync3_share_sched #(.NSRC(4), .DWIDTH(8), .SETTLE(4), .AUTOSCAN(0), .RESET_VAL(0)) dut0 (
        .clk(clk), .rst(rst), .src_data_in(src_data_in), .src_en(src_en0), .src_req(src_req),
        .snap_data(snap_data0), .snap_valid(snap_valid0), .snap_seen(snap_seen0),
        .busy(busy0), .state_dbg(st0)
    );

    c3lib_sync3_share_sched #(.NSRC(4), .DWIDTH(8), .SETTLE(4), .AUTOSCAN(1), .RESET_VAL(0)) dut1 (
        .clk(clk), .rst(rst), .src_data_in(src_data_in), .src_en(src_en1), .src_req(src_req),
        .snap_data(snap_data1), .snap_valid(snap_valid1), .snap_seen(snap_seen1),
        .busy(busy1), .state_dbg(st1)
    );

    typedef struct {
        int         src;
        logic [7:0] data;
        logic [3:0] exp_valid;
        logic [7:0] exp_snap;
        logic [3:0] exp_seen;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        src_req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_src(input int k, input logic [7:0] v);
        src_data_in = (src_data_in & ~(32'hFF << (8 * k))) | (32'(v) << (8 * k));
    endtask

    function automatic logic [7:0] slice(input logic [31:0] bus, input int k);
        return 8'(bus >> (8 * k));
    endfunction

    initial begin
        logic [3:0] acc;
        int         cyc;

        vecs[0] = '{1, 8'hA5, 4'b0010, 8'hA5, 4'b0010};
        vecs[1] = '{0, 8'h3C, 4'b0001, 8'h3C, 4'b0011};
        vecs[2] = '{3, 8'hFF, 4'b1000, 8'hFF, 4'b1011};
        vecs[3] = '{2, 8'h00, 4'b0100, 8'h00, 4'b1111};
        vecs[4] = '{1, 8'h5A, 4'b0010, 8'h5A, 4'b1111};

        src_data_in = 32'h0;
        src_en0     = 4'hF;
        src_en1     = 4'h0;
        src_req     = 4'h0;
        do_reset();

        // Reset state
        check("reset_data0",  snap_data0, 32'h0);
        check("reset_valid0", 32'(snap_valid0), 32'h0);
        check("reset_seen0",  32'(snap_seen0), 32'h0);
        check("reset_busy0",  32'(busy0), 32'h0);
        check("reset_data1",  snap_data1, 32'h0);

        // Single requests: latency, data and sticky seen
        for (int r = 0; r < 5; r++) begin
            set_src(vecs[r].src, vecs[r].data);
            src_req = 4'b0001 << vecs[r].src;
            step();
            src_req = '0;
            acc = '0;
            for (int c = 1; c <= 4; c++) begin
                step();
                acc |= snap_valid0;
                if (c == 1) check("busy_settle", 32'(busy0), 32'h1);
            end
            check("early_valid", 32'(acc), 32'h0);
            step();
            check("cap_valid", 32'(snap_valid0), 32'(vecs[r].exp_valid));
            check("cap_data",  32'(slice(snap_data0, vecs[r].src)), 32'(vecs[r].exp_snap));
            check("cap_seen",  32'(snap_seen0), 32'(vecs[r].exp_seen));
            step();
            check("valid_one_cycle", 32'(snap_valid0), 32'h0);
        end
        check("all_disabled_idle", 32'(busy1), 32'h0);

        // All four requested in one cycle: order 0..3, one capture every 6 cycles
        do_reset();
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_cyc_q = '{5, 11, 17, 23};
        src_req = 4'hF;
        step();
        src_req = '0;
        for (cyc = 1; cyc <= 30; cyc++) begin
            step();
            if (snap_valid0 != '0) begin
                if (exp_q.size() == 0) begin
                    check("burst_stray", 32'(snap_valid0), 32'h0);
                end else begin
                    check("burst_order", 32'(snap_valid0), 32'(exp_q.pop_front()));
                    check("burst_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                end
            end
            if (cyc == 1 || cyc == 7 || cyc == 13 || cyc == 19)
                check("burst_busy", 32'(busy0), 32'h1);
        end
        check("burst_missing", 32'(exp_q.size()), 32'h0);
        check("burst_idle", 32'(busy0), 32'h0);

        // Autoscan over sources 1 and 3
        src_en0 = 4'h0;
        src_en1 = 4'b1010;
        src_data_in = 32'h44332211;
        do_reset();
        exp_q = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010};
        exp_cyc_q = '{6, 12, 18, 24, 30};
        for (cyc = 1; cyc <= 30; cyc++) begin
            step();
            if (snap_valid1 != '0) begin
                if (exp_q.size() == 0) begin
                    check("scan_stray", 32'(snap_valid1), 32'h0);
                end else begin
                    check("scan_order", 32'(snap_valid1), 32'(exp_q.pop_front()));
                    check("scan_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                end
            end
        end
        check("scan_missing", 32'(exp_q.size()), 32'h0);
        check("scan_data", snap_data1, 32'h44002200);
        check("scan_seen", 32'(snap_seen1), 32'b1010);
        check("scan_dut0_idle", 32'(busy0), 32'h0);
        src_en1 = 4'h0;

        // Request for source 2 landing on its own capture cycle
        src_en0 = 4'hF;
        do_reset();
        set_src(2, 8'h66);
        src_req = 4'b0100;
        step();
        src_req = '0;
        repeat (3) step();
        step();
        src_req = 4'b0100;
        step();
        src_req = '0;
        check("rereq_first", 32'(snap_valid0), 32'b0100);
        acc = '0;
        for (int e = 6; e <= 20; e++) begin
            step();
            if (e == 11) check("rereq_second", 32'(snap_valid0), 32'b0100);
            else         acc |= snap_valid0;
        end
        check("rereq_stray", 32'(acc), 32'h0);
        check("rereq_data", 32'(slice(snap_data0, 2)), 32'h66);

        // Reset during SETTLE abandons the capture
        set_src(1, 8'h99);
        src_req = 4'b0010;
        step();
        src_req = '0;
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_data",  snap_data0, 32'h0);
        check("midrst_valid", 32'(snap_valid0), 32'h0);
        check("midrst_seen",  32'(snap_seen0), 32'h0);
        check("midrst_busy",  32'(busy0), 32'h0);
        check("midrst_state", 32'(st0), 32'(ST_IDLE));
        rst = 1'b0;
        acc = '0;
        repeat (10) begin
            step();
            acc |= snap_valid0;
        end
        check("midrst_no_pulse", 32'(acc), 32'h0);

        // Snapshot changes only at capture
        set_src(0, 8'h00);
        src_req = 4'b0001;
        step();
        src_req = '0;
        repeat (5) step();
        check("hold_first", 32'(slice(snap_data0, 0)), 32'h00);
        set_src(0, 8'hFF);
        acc = '0;
        repeat (10) begin
            step();
            if (slice(snap_data0, 0) != 8'h00) acc = 4'b0001;
        end
        check("hold_between", 32'(acc), 32'h0);
        src_req = 4'b0001;
        step();
        src_req = '0;
        repeat (5) step();
        check("hold_update_valid", 32'(snap_valid0), 32'b0001);
        check("hold_update_data",  32'(slice(snap_data0, 0)), 32'hFF);

        // Enable dropped mid-SETTLE: capture completes, later requests blocked
        set_src(3, 8'hC3);
        src_req = 4'b1000;
        step();
        src_req = '0;
        step();
        src_en0 = 4'b0111;
        repeat (3) step();
        step();
        check("endrop_valid", 32'(snap_valid0), 32'b1000);
        check("endrop_data",  32'(slice(snap_data0, 3)), 32'hC3);
        step();
        src_req = 4'b1000;
        step();
        src_req = '0;
        acc = '0;
        repeat (10) begin
            step();
            acc |= snap_valid0;
        end
        check("endrop_blocked", 32'(acc), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
